stream_demux_1_to_4: RTL and testbench

Packet-aware 1-to-4 stream demultiplexer, the return path to the 4:1 select mux. It routes one valid/ready input stream to one of four output channels. The channel is chosen by `in_sel` on the first beat of a packet and locked until that packet's last beat. Each output has a one-entry register stage, and per-channel packet counters support debug.

---
 rtl/stream_demux_pkg.sv | 6 +
 rtl/stream_reg_slice.sv | 29 ++
 rtl/stream_demux_1_to_4.sv | 66 ++++++
 tb/tb_stream_demux_1_to_4.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared constants and FSM state type for the 1-to-4 stream demux
package stream_demux_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  typedef enum logic {S_IDLE, S_BUSY} state_t;
endpackage

// File: rtl/stream_reg_slice.sv
// stream_reg_slice: one-entry valid/ready output stage holding a data beat and its last flag
// ports: clk, rst, load (accept new beat), in_data/in_last (beat), ready (downstream accept), data/last/valid (staged beat)
module stream_reg_slice #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic              valid
);
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      last  <= 1'b0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= in_data;
      last  <= in_last;
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/stream_demux_1_to_4.sv
// stream_demux_1_to_4: packet-aware 1-to-4 valid/ready demux with per-channel output stages and packet counters
// ports: clk, rst; in_data/in_sel/in_last/in_valid/in_ready input stream;
// out_data/out_last/out_valid/out_ready four packed output streams; pkt_cnt per-channel completed packets; busy packet open
module stream_demux_1_to_4
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [SEL_W-1:0]           in_sel,
  input  logic                       in_last,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [NUM_CH*DATA_W-1:0]   out_data,
  output logic [NUM_CH-1:0]          out_last,
  output logic [NUM_CH-1:0]          out_valid,
  input  logic [NUM_CH-1:0]          out_ready,
  output logic [NUM_CH*CNT_W-1:0]    pkt_cnt,
  output logic                       busy
);
  state_t             state;
  logic [SEL_W-1:0]   lock_ch;
  logic [SEL_W-1:0]   tgt;
  logic               acc;
  logic [NUM_CH-1:0]  load;
  logic [CNT_W-1:0]   cnt [NUM_CH];
  assign tgt      = (state == S_IDLE) ? in_sel : lock_ch;
  assign in_ready = !out_valid[tgt] || out_ready[tgt];
  assign acc      = in_valid && in_ready;
  assign load     = acc ? (NUM_CH'(1) << tgt) : '0;
  assign busy     = (state == S_BUSY);
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      lock_ch <= '0;
    end else if (acc) begin
      if (state == S_IDLE && !in_last) begin
        state   <= S_BUSY;
        lock_ch <= in_sel;
      end else if (state == S_BUSY && in_last) begin
        state <= S_IDLE;
      end
    end
  end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    stream_reg_slice #(.DATA_W(DATA_W)) u_slice (
      .clk     (clk),
      .rst     (rst),
      .load    (load[g]),
      .in_data (in_data),
      .in_last (in_last),
      .ready   (out_ready[g]),
      .data    (out_data[g*DATA_W +: DATA_W]),
      .last    (out_last[g]),
      .valid   (out_valid[g])
    );
    always_ff @(posedge clk) begin
      if (rst) cnt[g] <= '0;
      else if (out_valid[g] && out_ready[g] && out_last[g]) cnt[g] <= cnt[g] + 1'b1;
    end
    assign pkt_cnt[g*CNT_W +: CNT_W] = cnt[g];
  end
endmodule

// File: tb/tb_stream_demux_1_to_4.sv
// tb_stream_demux_1_to_4: scoreboard bench for the 1-to-4 packet demux
module tb_stream_demux_1_to_4;
  localparam int DW = 8;
  localparam int CW = 8;
  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic [1:0]    in_sel;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;
  logic [4*DW-1:0] out_data;
  logic [3:0]    out_last;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [4*CW-1:0] pkt_cnt;
  logic          busy;
  int n_chk = 0;
  int n_pass = 0;
  logic [DW:0] q [4][$];
  int   cnt_m [4];
  logic busy_m;
  logic [1:0] lock_m;
  int   w;
  always #5 clk = ~clk;
  stream_demux_1_to_4 #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .pkt_cnt(pkt_cnt), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (q[k].size() == 0) begin
            chk($sformatf("unexpected_beat_ch%0d", k), 32'(q[k].size()), 32'd1);
          end else begin
            logic [DW:0] e;
            e = q[k].pop_front();
            chk($sformatf("data_ch%0d", k), 32'(out_data[k*DW +: DW]), 32'(e[DW-1:0]));
            chk($sformatf("last_ch%0d", k), 32'(out_last[k]), 32'(e[DW]));
            if (e[DW]) cnt_m[k] = (cnt_m[k] + 1) % 256;
          end
        end
      end
    end
  end
  task automatic send(input logic [DW-1:0] d, input logic [1:0] s, input logic l, output int waits);
    logic [1:0] t;
    logic ok;
    in_data = d; in_sel = s; in_last = l; in_valid = 1'b1;
    waits = 0; ok = 1'b0;
    while (!ok && waits <= 50) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else begin
        waits++;
        @(posedge clk); #1;
      end
    end
    if (!ok) chk("send_timeout", 32'(waits), 32'd0);
    else begin
      t = busy_m ? lock_m : s;
      q[t].push_back({l, d});
      if (!busy_m && !l) begin busy_m = 1'b1; lock_m = s; end
      else if (busy_m && l) busy_m = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin q[k].delete(); cnt_m[k] = 0; end
    busy_m = 1'b0; lock_m = 2'd0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_cnts(input string tag);
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s_cnt%0d", tag, k), 32'(pkt_cnt[k*CW +: CW]), 32'(cnt_m[k]));
  endtask
  initial begin
    in_data = '0; in_sel = 2'd2; in_last = 1'b0; in_valid = 1'b0; out_ready = 4'hF; rst = 1'b0;
    busy_m = 1'b0; lock_m = 2'd0;
    for (int k = 0; k < 4; k++) cnt_m[k] = 0;
    do_reset();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_pkt_cnt", pkt_cnt, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    send(8'hA1, 2'd2, 1'b0, w);
    chk("lock_busy", 32'(busy), 32'd1);
    send(8'hA2, 2'd0, 1'b0, w);
    send(8'hA3, 2'd3, 1'b1, w);
    chk("lock_busy_end", 32'(busy), 32'd0);
    idle(3);
    chk("lock_cnt2", 32'(pkt_cnt[2*CW +: CW]), 32'd1);
    chk("lock_cnt_others", 32'({pkt_cnt[3*CW +: CW], pkt_cnt[1*CW +: CW], pkt_cnt[0 +: CW]}), 32'd0);
    chk_cnts("lock");
    out_ready[1] = 1'b0;
    send(8'hB1, 2'd1, 1'b0, w);
    in_data = 8'hB2; in_sel = 2'd1; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_data", 32'(out_data[1*DW +: DW]), 32'hB1);
      chk("bp_hold_valid", 32'(out_valid[1]), 32'd1);
      @(posedge clk); #1;
    end
    out_ready[1] = 1'b1;
    send(8'hB2, 2'd1, 1'b1, w);
    chk("bp_release_wait", 32'(w), 32'd0);
    chk("bp_busy_fall", 32'(busy), 32'd0);
    idle(3);
    chk_cnts("bp");
    out_ready[0] = 1'b0;
    send(8'hC0, 2'd0, 1'b1, w);
    send(8'hC3, 2'd3, 1'b1, w);
    chk("ind_wait", 32'(w), 32'd0);
    chk("ind_valid3", 32'(out_valid[3]), 32'd1);
    chk("ind_data3", 32'(out_data[3*DW +: DW]), 32'hC3);
    chk("ind_data0", 32'(out_data[0 +: DW]), 32'hC0);
    idle(2);
    chk("ind_data0_hold", 32'(out_data[0 +: DW]), 32'hC0);
    out_ready[0] = 1'b1;
    idle(3);
    chk_cnts("ind");
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send(8'(i), 2'd1, 1'b1, w);
      if (i == 99) begin
        @(negedge clk);
        chk("wrap_mid_cnt1", 32'(pkt_cnt[1*CW +: CW]), 32'd99);
        @(posedge clk); #1;
      end
    end
    idle(3);
    chk("wrap_cnt1", 32'(pkt_cnt[1*CW +: CW]), 32'd0);
    chk_cnts("wrap");
    send(8'hD1, 2'd0, 1'b0, w);
    send(8'hD2, 2'd0, 1'b0, w);
    do_reset();
    chk("mid_rst_valid0", 32'(out_valid[0]), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    send(8'hE1, 2'd1, 1'b1, w);
    idle(4);
    chk("mid_rst_valid0_after", 32'(out_valid[0]), 32'd0);
    chk("mid_rst_cnt1", 32'(pkt_cnt[1*CW +: CW]), 32'd1);
    chk("mid_rst_cnt0", 32'(pkt_cnt[0 +: CW]), 32'd0);
    for (int k = 0; k < 4; k++) chk($sformatf("drain_q%0d", k), 32'(q[k].size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
